// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + PC + valid, with stall/flush
// control and saturating per-stage stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned            DATA_W           = 160,
    parameter int unsigned            PC_W             = 32,
    parameter logic [PC_W-1:0]        RESET_PC         = 32'h0000_3000,
    parameter bit                     FLUSH_OVER_STALL = 1'b1,
    parameter bit                     KEEP_PC_ON_FLUSH = 1'b1,
    parameter int unsigned            CNT_W            = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_payload,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_payload,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2
    } action_e;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [PC_W-1:0]   PC_ZERO   = {PC_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    action_e             action_s;
    logic                valid_r;
    logic [PC_W-1:0]     pc_r;
    logic [DATA_W-1:0]   payload_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [CNT_W-1:0]    bubble_cnt_r;
    logic                valid_s;
    logic [PC_W-1:0]     pc_s;
    logic [DATA_W-1:0]   payload_s;
    logic [CNT_W-1:0]    stall_cnt_s;
    logic [CNT_W-1:0]    bubble_cnt_s;

    // Resolve the effective action from stall/flush according to the priority option.
    always_comb begin
        action_s = ACT_LOAD;
        if (FLUSH_OVER_STALL) begin
            if (flush) begin
                action_s = ACT_FLUSH;
            end else if (stall) begin
                action_s = ACT_STALL;
            end else begin
                action_s = ACT_LOAD;
            end
        end else begin
            if (stall) begin
                action_s = ACT_STALL;
            end else if (flush) begin
                action_s = ACT_FLUSH;
            end else begin
                action_s = ACT_LOAD;
            end
        end
    end

    // Next data contents; an invalid slot always carries an all-zero payload.
    always_comb begin
        valid_s   = valid_r;
        pc_s      = pc_r;
        payload_s = payload_r;
        case (action_s)
            ACT_LOAD: begin
                valid_s   = in_valid;
                pc_s      = in_pc;
                payload_s = in_valid ? in_payload : DATA_ZERO;
            end
            ACT_FLUSH: begin
                valid_s   = 1'b0;
                pc_s      = KEEP_PC_ON_FLUSH ? in_pc : PC_ZERO;
                payload_s = DATA_ZERO;
            end
            ACT_STALL: begin
                valid_s   = valid_r;
                pc_s      = pc_r;
                payload_s = payload_r;
            end
            default: begin
                valid_s   = 1'b0;
                pc_s      = pc_r;
                payload_s = DATA_ZERO;
            end
        endcase
    end

    // Next counter values; a clear discards any increment on the same edge.
    always_comb begin
        stall_cnt_s  = stall_cnt_r;
        bubble_cnt_s = bubble_cnt_r;
        if (cnt_clr) begin
            stall_cnt_s  = CNT_ZERO;
            bubble_cnt_s = CNT_ZERO;
        end else if (action_s == ACT_STALL) begin
            stall_cnt_s  = sat_inc(stall_cnt_r);
        end else if (action_s == ACT_FLUSH) begin
            bubble_cnt_s = sat_inc(bubble_cnt_r);
        end else begin
            stall_cnt_s  = stall_cnt_r;
            bubble_cnt_s = bubble_cnt_r;
        end
    end

    // State register with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r      <= 1'b0;
            pc_r         <= RESET_PC;
            payload_r    <= DATA_ZERO;
            stall_cnt_r  <= CNT_ZERO;
            bubble_cnt_r <= CNT_ZERO;
        end else begin
            valid_r      <= valid_s;
            pc_r         <= pc_s;
            payload_r    <= payload_s;
            stall_cnt_r  <= stall_cnt_s;
            bubble_cnt_r <= bubble_cnt_s;
        end
    end

    assign out_valid   = valid_r;
    assign out_pc      = pc_r;
    assign out_payload = payload_r;
    assign stall_cnt   = stall_cnt_r;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: instance A uses flush priority / PC kept on flush,
// instance B uses stall priority / PC zeroed on flush with 4-bit counters.
module tb_pipe_stage_reg;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         flush;
    logic         cnt_clr;
    logic         in_valid;
    logic [31:0]  in_pc;
    logic [159:0] in_payload;

    logic         out_valid_a;
    logic [31:0]  out_pc_a;
    logic [159:0] out_payload_a;
    logic [31:0]  stall_cnt_a;
    logic [31:0]  bubble_cnt_a;

    logic         out_valid_b;
    logic [31:0]  out_pc_b;
    logic [159:0] out_payload_b;
    logic [3:0]   stall_cnt_b;
    logic [3:0]   bubble_cnt_b;

    int n_checks;
    int n_fails;

    pipe_stage_reg #(
        .DATA_W(160), .PC_W(32), .RESET_PC(32'h0000_3000),
        .FLUSH_OVER_STALL(1'b1), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(32)
    ) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload),
        .out_valid(out_valid_a), .out_pc(out_pc_a), .out_payload(out_payload_a),
        .stall_cnt(stall_cnt_a), .bubble_cnt(bubble_cnt_a)
    );

    pipe_stage_reg #(
        .DATA_W(160), .PC_W(32), .RESET_PC(32'h0000_3000),
        .FLUSH_OVER_STALL(1'b0), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload),
        .out_valid(out_valid_b), .out_pc(out_pc_b), .out_payload(out_payload_b),
        .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] pc,
                         input logic [159:0] pl, input logic [31:0] sc, input logic [31:0] bc);
        chk({tag, "_a_valid"}, {159'd0, out_valid_a}, {159'd0, v});
        chk({tag, "_a_pc"}, {128'd0, out_pc_a}, {128'd0, pc});
        chk({tag, "_a_payload"}, out_payload_a, pl);
        chk({tag, "_a_stall_cnt"}, {128'd0, stall_cnt_a}, {128'd0, sc});
        chk({tag, "_a_bubble_cnt"}, {128'd0, bubble_cnt_a}, {128'd0, bc});
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [31:0] pc,
                         input logic [159:0] pl, input logic [3:0] sc, input logic [3:0] bc);
        chk({tag, "_b_valid"}, {159'd0, out_valid_b}, {159'd0, v});
        chk({tag, "_b_pc"}, {128'd0, out_pc_b}, {128'd0, pc});
        chk({tag, "_b_payload"}, out_payload_b, pl);
        chk({tag, "_b_stall_cnt"}, {156'd0, stall_cnt_b}, {156'd0, sc});
        chk({tag, "_b_bubble_cnt"}, {156'd0, bubble_cnt_b}, {156'd0, bc});
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic c,
                         input logic v, input logic [31:0] pc, input logic [159:0] pl);
        reset = r; stall = s; flush = f; cnt_clr = c;
        in_valid = v; in_pc = pc; in_payload = pl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 160'h0);
        tick();
        chk_a("reset", 1'b0, 32'h3000, 160'h0, 32'd0, 32'd0);
        chk_b("reset", 1'b0, 32'h3000, 160'h0, 4'd0, 4'd0);

        // Load, also confirming no same-cycle input-to-output path
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 160'hABC);
        #1;
        chk("no_comb_path_pc", {128'd0, out_pc_a}, {128'd0, 32'h3000});
        tick();
        chk_a("load", 1'b1, 32'h3004, 160'hABC, 32'd0, 32'd0);
        chk_b("load", 1'b1, 32'h3004, 160'hABC, 4'd0, 4'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3008, 160'h11);
        tick();
        chk_a("load2", 1'b1, 32'h3008, 160'h11, 32'd0, 32'd0);

        // Stall three cycles while upstream changes
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300C, 160'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_pc", {128'd0, out_pc_a}, {128'd0, 32'h3008});
        end
        chk_a("stall3", 1'b1, 32'h3008, 160'h11, 32'd3, 32'd0);
        chk_b("stall3", 1'b1, 32'h3008, 160'h11, 4'd3, 4'd0);

        stall = 1'b0;
        tick();
        chk_a("release", 1'b1, 32'h300C, 160'h22, 32'd3, 32'd0);
        chk_b("release", 1'b1, 32'h300C, 160'h22, 4'd3, 4'd0);

        // Flush: A keeps PC, B zeroes it
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3010, 160'hFFFF);
        tick();
        chk_a("flush", 1'b0, 32'h3010, 160'h0, 32'd3, 32'd1);
        chk_b("flush", 1'b0, 32'h0, 160'h0, 4'd3, 4'd1);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3018, 160'h77);
        tick();
        chk_a("load3", 1'b1, 32'h3018, 160'h77, 32'd3, 32'd1);
        chk_b("load3", 1'b1, 32'h3018, 160'h77, 4'd3, 4'd1);

        // Simultaneous stall+flush: A flushes, B holds
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h301C, 160'h99);
        tick();
        chk_a("stall_flush", 1'b0, 32'h301C, 160'h0, 32'd3, 32'd2);
        chk_b("stall_flush", 1'b1, 32'h3018, 160'h77, 4'd4, 4'd1);

        // Invalid slot presents zero payload
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3020, 160'h1234);
        tick();
        chk_a("invalid", 1'b0, 32'h3020, 160'h0, 32'd3, 32'd2);
        chk_b("invalid", 1'b0, 32'h3020, 160'h0, 4'd4, 4'd1);

        // Twenty stalls saturate the 4-bit counter
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3024, 160'h5);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk_a("saturate", 1'b0, 32'h3020, 160'h0, 32'd23, 32'd2);
        chk_b("saturate", 1'b0, 32'h3020, 160'h0, 4'd15, 4'd1);

        cnt_clr = 1'b1;
        tick();
        chk_a("clear", 1'b0, 32'h3020, 160'h0, 32'd0, 32'd0);
        chk_b("clear", 1'b0, 32'h3020, 160'h0, 4'd0, 4'd0);

        cnt_clr = 1'b0;
        tick();
        chk_a("after_clear", 1'b0, 32'h3020, 160'h0, 32'd1, 32'd0);
        chk_b("after_clear", 1'b0, 32'h3020, 160'h0, 4'd1, 4'd0);

        // Reset while stalling and flushing
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3028, 160'h66);
        tick();
        chk_a("reset_mid", 1'b0, 32'h3000, 160'h0, 32'd0, 32'd0);
        chk_b("reset_mid", 1'b0, 32'h3000, 160'h0, 4'd0, 4'd0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h302C, 160'h88);
        tick();
        chk_a("post_reset_stall", 1'b0, 32'h3000, 160'h0, 32'd1, 32'd0);
        chk_b("post_reset_stall", 1'b0, 32'h3000, 160'h0, 4'd1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register; supersedes the fixed-field per-stage registers (F/D, D/E, E/M, M/W).
- Carries an opaque payload bus (instruction, operands, control) plus a PC and a valid bit.
- Supports stall (hold), flush (bubble insertion) with configurable priority, and optional PC retention on flush for exception/BD tracking.
- Keeps saturating stall/bubble performance counters per stage.

Parameters:
- DATA_W, 160: payload width in bits.
- PC_W, 32: PC field width.
- RESET_PC, 32'h0000_3000: out_pc value after reset.
- FLUSH_OVER_STALL, 1: 1 = flush wins when stall and flush are both high; 0 = stall wins.
- KEEP_PC_ON_FLUSH, 1: 1 = a bubble captures in_pc; 0 = a bubble sets out_pc to 0.
- CNT_W, 32: performance counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold current contents.
- flush  input  1  insert bubble.
- cnt_clr  input  1  synchronous clear of both counters.
- in_valid  input  1  upstream slot holds a real instruction.
- in_pc  input  PC_W  upstream PC.
- in_payload  input  DATA_W  upstream payload.
- out_valid  output  1  registered valid.
- out_pc  output  PC_W  registered PC.
- out_payload  output  DATA_W  registered payload.
- stall_cnt  output  CNT_W  cycles in which stall was the effective action.
- bubble_cnt  output  CNT_W  bubbles inserted by flush.

Behaviour:
- All state updates on posedge clk only. Outputs are driven directly from registers, with no combinational path from input to output. Latency is 1 cycle.
- Reset is synchronous and active-high. On reset: out_valid=0, out_payload=0, out_pc=RESET_PC, stall_cnt=0, bubble_cnt=0. Reset overrides every other input.
- Effective action per cycle when reset=0:
  - FLUSH_OVER_STALL=1: flush > stall > load.
  - FLUSH_OVER_STALL=0: stall > flush > load.
- LOAD: out_valid<=in_valid, out_pc<=in_pc.
  - out_payload<=in_payload if in_valid=1, else 0. An invalid slot always presents all-zero payload (nop).
- STALL: all three data outputs hold their values. stall_cnt increments.
- FLUSH: out_valid<=0, out_payload<=0.
  - out_pc<=in_pc if KEEP_PC_ON_FLUSH=1, else 0.
  - bubble_cnt increments.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces both counters to 0 on that edge. Any same-cycle increment is discarded (clear wins).
  - cnt_clr has no effect on data outputs.
- Stall held for N cycles: outputs are unchanged for N edges. The first edge with stall=0 loads the current inputs; no upstream data is captured during the stall.
- Reset asserted mid-stall or mid-flush: reset values apply on that edge. Counting restarts from 0 on the next edge.
- Inputs are sampled only at the edge. Glitches between edges have no effect.

Test Plan:
- Reset then LOAD:
  - Apply reset 1 cycle → out_valid=0, out_payload=0, out_pc=32'h3000, counters 0.
  - Next edge with in_valid=1, in_pc=32'h3004, in_payload=0xABC → outputs reflect these values exactly 1 edge later.
- Stall hold:
  - Load pc 32'h3008.
  - Assert stall 3 cycles while in_pc changes to 32'h300C → out_pc stays 32'h3008 and stall_cnt=3.
  - Release stall → out_pc=32'h300C on the next edge.
- Flush with KEEP_PC_ON_FLUSH=1:
  - flush with in_pc=32'h3010, in_payload=0xFFFF → out_valid=0, out_payload=0, out_pc=32'h3010, bubble_cnt=1.
  - Repeat with KEEP_PC_ON_FLUSH=0 → out_pc=0.
- Simultaneous stall+flush:
  - FLUSH_OVER_STALL=1 → bubble inserted, bubble_cnt+1, stall_cnt unchanged.
  - FLUSH_OVER_STALL=0 → previous contents held, stall_cnt+1, bubble_cnt unchanged.
- Counter saturation/clear (CNT_W=4):
  - 20 consecutive stalls → stall_cnt=15.
  - cnt_clr together with stall → stall_cnt=0.
  - Next stall edge → stall_cnt=1.
- Invalid input and reset mid-stall:
  - in_valid=0 with in_payload=0x1234 → out_payload=0, out_valid=0.
  - During an active stall, assert reset → reset values on that edge, counters 0.
